// File: rtl/conv_deserializer.sv
// Receive side of the conv 2:1 DDR serial link: recovers bit pairs on both clock edges,
// packs them into words and locks word alignment onto a repeated sync word.
module conv_deserializer #(
    parameter int                 PAIRS      = 4,
    parameter logic [2*PAIRS-1:0] SYNC_WORD  = 8'hB4,
    parameter int                 LOCK_COUNT = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               SERIAL_IN,
    input  logic               RESYNC,
    output logic               PAR_OUT1,
    output logic               PAR_OUT2,
    output logic               PAIR_VALID,
    output logic [2*PAIRS-1:0] WORD_OUT,
    output logic               WORD_VALID,
    output logic               LOCKED,
    output logic               ALIGN_ERR,
    output logic [1:0]         dbg_state
);
    localparam int WORD_W = 2 * PAIRS;
    localparam int FC_W   = $clog2(PAIRS + 1);
    localparam int PH_W   = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int MC_W   = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            state;
    logic              neg_q;
    logic              started;
    logic [WORD_W-1:0] sr;
    logic [FC_W-1:0]   fill_cnt;
    logic [PH_W-1:0]   phase;
    logic [MC_W-1:0]   match_cnt;

    logic fill_full;
    logic boundary;
    logic sync_hit;

    assign fill_full = (fill_cnt == FC_W'(PAIRS));
    assign boundary  = (phase == '0);
    assign sync_hit  = (sr == SYNC_WORD);
    assign dbg_state = state;

    // High-phase bit, held across the low phase until the next rising edge.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= SERIAL_IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PAR_OUT1   <= 1'b0;
            PAR_OUT2   <= 1'b0;
            PAIR_VALID <= 1'b0;
            WORD_OUT   <= '0;
            WORD_VALID <= 1'b0;
            LOCKED     <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            started    <= 1'b0;
            sr         <= '0;
            fill_cnt   <= '0;
            phase      <= '0;
            match_cnt  <= '0;
            state      <= ST_HUNT;
        end else begin
            PAR_OUT1   <= SERIAL_IN;
            PAR_OUT2   <= neg_q;
            sr         <= {sr[WORD_W-3:0], SERIAL_IN, neg_q};
            started    <= 1'b1;
            PAIR_VALID <= started;
            WORD_VALID <= 1'b0;
            ALIGN_ERR  <= 1'b0;
            if (started && !fill_full) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            phase <= (phase == PH_W'(PAIRS - 1)) ? '0 : phase + 1'b1;

            // Fill count and sr survive RESYNC so HUNT can match on the very next cycle.
            if (RESYNC) begin
                state     <= ST_HUNT;
                LOCKED    <= 1'b0;
                match_cnt <= '0;
            end else begin
                case (state)
                    ST_HUNT: begin
                        if (fill_full && sync_hit) begin
                            phase     <= PH_W'((PAIRS > 1) ? 1 : 0);
                            match_cnt <= MC_W'(1);
                            if (LOCK_COUNT == 1) begin
                                state  <= ST_LOCKED;
                                LOCKED <= 1'b1;
                            end else begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                    ST_CHECK: begin
                        if (boundary) begin
                            if (sync_hit) begin
                                match_cnt <= match_cnt + 1'b1;
                                if (match_cnt == MC_W'(LOCK_COUNT - 1)) begin
                                    state  <= ST_LOCKED;
                                    LOCKED <= 1'b1;
                                end
                            end else begin
                                ALIGN_ERR <= 1'b1;
                                match_cnt <= '0;
                                state     <= ST_HUNT;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (boundary) begin
                            WORD_OUT   <= sr;
                            WORD_VALID <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= ST_HUNT;
                        LOCKED    <= 1'b0;
                        match_cnt <= '0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_conv_deserializer.sv
// Directed bench for conv_deserializer: word-level vector tables plus hand-written
// reset, pair-capture and garbage-pair sequences.
module tb_conv_deserializer;
    logic       CLK;
    logic       RESET;
    logic       SERIAL_IN;
    logic       RESYNC;
    logic       PAR_OUT1;
    logic       PAR_OUT2;
    logic       PAIR_VALID;
    logic [7:0] WORD_OUT;
    logic       WORD_VALID;
    logic       LOCKED;
    logic       ALIGN_ERR;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] held_word = 8'h00;

    conv_deserializer dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .SERIAL_IN  (SERIAL_IN),
        .RESYNC     (RESYNC),
        .PAR_OUT1   (PAR_OUT1),
        .PAR_OUT2   (PAR_OUT2),
        .PAIR_VALID (PAIR_VALID),
        .WORD_OUT   (WORD_OUT),
        .WORD_VALID (WORD_VALID),
        .LOCKED     (LOCKED),
        .ALIGN_ERR  (ALIGN_ERR),
        .dbg_state  (dbg_state)
    );

    // Clock: rising edges at 5, 15, 25 ...; high for the first half of each period.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One record per word: expectations apply at the word's first pair (the boundary
    // where the FSM judges the previous word); LOCKED holds for all four pairs.
    typedef struct packed {
        logic [7:0] word;
        logic       rs;
        logic       locked;
        logic       wv;
        logic       err;
        logic [7:0] ow;
    } vec_t;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drives one pair (b2 while CLK high, b1 while CLK low), then checks just after
    // the rising edge that captures it.
    task automatic run_pair(input logic b1, input logic b2, input logic rs,
                            input logic e_pv, input logic e_locked, input logic e_wv,
                            input logic e_err, input logic [7:0] e_word);
        SERIAL_IN = b2;
        RESYNC    = rs;
        @(negedge CLK);
        #1 SERIAL_IN = b1;
        @(posedge CLK);
        #1 RESYNC = 1'b0;
        if (e_wv) held_word = e_word;
        chk("par_out1",   {7'd0, PAR_OUT1},   {7'd0, b1});
        chk("par_out2",   {7'd0, PAR_OUT2},   {7'd0, b2});
        chk("pair_valid", {7'd0, PAIR_VALID}, {7'd0, e_pv});
        chk("locked",     {7'd0, LOCKED},     {7'd0, e_locked});
        chk("word_valid", {7'd0, WORD_VALID}, {7'd0, e_wv});
        chk("align_err",  {7'd0, ALIGN_ERR},  {7'd0, e_err});
        chk("word_out",   WORD_OUT,           held_word);
    endtask

    task automatic run_word(input vec_t v);
        for (int i = 0; i < 4; i++) begin
            if (i == 0)
                run_pair(v.word[7], v.word[6], v.rs, 1'b1, v.locked, v.wv, v.err, v.ow);
            else
                run_pair(v.word[7-2*i], v.word[6-2*i], 1'b0, 1'b1, v.locked, 1'b0, 1'b0, v.ow);
        end
    endtask

    // Assert reset in the middle of CLK high, check outputs clear without a clock edge,
    // then release mid-high so a falling edge precedes the first rising edge.
    task automatic do_reset();
        @(posedge CLK);
        #2 RESET = 1'b1;
        #1;
        chk("rst_par_out1",   {7'd0, PAR_OUT1},   8'h00);
        chk("rst_par_out2",   {7'd0, PAR_OUT2},   8'h00);
        chk("rst_pair_valid", {7'd0, PAIR_VALID}, 8'h00);
        chk("rst_word_out",   WORD_OUT,           8'h00);
        chk("rst_word_valid", {7'd0, WORD_VALID}, 8'h00);
        chk("rst_locked",     {7'd0, LOCKED},     8'h00);
        chk("rst_align_err",  {7'd0, ALIGN_ERR},  8'h00);
        chk("rst_state",      {6'd0, dbg_state},  8'h00);
        @(negedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b0;
        held_word = 8'h00;
        // First rising edge after release: pair not yet valid.
        run_pair(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++)
            run_pair(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Sync word followed by a non-sync word: failed check, no lock.
    vec_t tbl_bad[3] = '{
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00}
    };

    // Lock on three syncs, emit, resync on a boundary (5A dropped), relock, emit.
    vec_t tbl_lock[11] = '{
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00},
        '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C},
        '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00},
        '{8'hB4, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'h96, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00},
        '{8'hE7, 1'b0, 1'b1, 1'b1, 1'b0, 8'h96}
    };

    // After a reset: two syncs leave LOCKED low, the third locks.
    vec_t tbl_relock[5] = '{
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00},
        '{8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00},
        '{8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h5A}
    };

    initial begin
        RESET     = 1'b0;
        SERIAL_IN = 1'b0;
        RESYNC    = 1'b0;

        do_reset();

        // Single pair: 1 while high, 0 while low.
        run_pair(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        foreach (tbl_bad[i]) run_word(tbl_bad[i]);
        chk("hunt_after_err", {6'd0, dbg_state}, 8'h00);

        // One garbage pair shifts the sync words off the previous pair grid.
        run_pair(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        foreach (tbl_lock[i]) run_word(tbl_lock[i]);

        // Two pairs into the next word (E7 emitted at the boundary), then reset mid-word.
        run_pair(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'hE7);
        run_pair(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hE7);
        do_reset();

        foreach (tbl_relock[i]) run_word(tbl_relock[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Time limit so the run always terminates.
    initial begin
        #200000;
        n_fail++;
        $display("FAIL timeout: simulation did not complete, limit 200000 reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
